// File: rtl/rne_pkg.sv
// Shared types and constants for the round-to-nearest-even datapath.
package rne_pkg;

    localparam int unsigned FRAC_W  = 8;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned TRAIL_W = 2;

    // Exponent value reserved for infinity/NaN; rounding saturates here.
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    // Decided beat held between the decide and apply stages.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              round_up;
        logic              inexact;
    } s1_payload_t;

    // Rounded beat presented on the output side.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              inexact;
        logic              overflow;
    } s2_payload_t;

endpackage

// File: rtl/rne_round_decide.sv
// Round-to-nearest-even decision from the fraction LSB and the discarded bits.
// Purely combinational so it can be dropped into other rounding sites.
module rne_round_decide #(
    parameter int unsigned TRAILING_BITS = 2
) (
    input  logic                     frac_lsb,
    input  logic [TRAILING_BITS-1:0] trailing,
    input  logic                     sticky,
    input  logic                     exp_max,
    output logic                     round_up,
    output logic                     inexact
);

    logic round_bit;
    logic sticky_all;

    assign round_bit = trailing[TRAILING_BITS-1];

    // Everything below the round bit collapses into one sticky term.
    if (TRAILING_BITS > 1) begin : g_multi_trailing
        assign sticky_all = sticky | (|trailing[TRAILING_BITS-2:0]);
    end else begin : g_single_trailing
        assign sticky_all = sticky;
    end

    // Ties go to even; an all-ones exponent is never rounded.
    assign round_up = round_bit & (sticky_all | frac_lsb) & ~exp_max;
    assign inexact  = round_bit | sticky_all;

endmodule

// File: rtl/rne_round_pipe.sv
// Two-stage pipelined round-to-nearest-even with valid/ready on both sides.
// Stage 1 decides the round-up, stage 2 applies the increment and carry.
module rne_round_pipe
    import rne_pkg::*;
#(
    parameter int unsigned FRAC          = FRAC_W,
    parameter int unsigned EXP           = EXP_W,
    parameter int unsigned TRAILING_BITS = TRAIL_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic                     inSign,
    input  logic [EXP-1:0]           inExp,
    input  logic [FRAC-1:0]          inFrac,
    input  logic [TRAILING_BITS-1:0] inTrailing,
    input  logic                     inSticky,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     outSign,
    output logic [EXP-1:0]           outExp,
    output logic [FRAC-1:0]          outFrac,
    output logic                     outInexact,
    output logic                     outOverflow
);

    s1_payload_t s1_data_d, s1_data_q;
    s2_payload_t s2_data_d, s2_data_q;
    logic        s1_valid_d, s1_valid_q;
    logic        s2_valid_d, s2_valid_q;
    logic        s1_load, s2_load;
    logic        dec_round_up, dec_inexact;
    logic        exp_max;
    logic [FRAC:0]  frac_sum;
    logic [EXP-1:0] exp_inc;

    assign exp_max = (inExp == EXP_ALL_ONES);

    rne_round_decide #(
        .TRAILING_BITS (TRAILING_BITS)
    ) u_decide (
        .frac_lsb (inFrac[0]),
        .trailing (inTrailing),
        .sticky   (inSticky),
        .exp_max  (exp_max),
        .round_up (dec_round_up),
        .inexact  (dec_inexact)
    );

    // Stage advance: no skid buffer, so inReady follows outReady combinationally.
    always_comb begin
        s2_load = !s2_valid_q || outReady;
        s1_load = !s1_valid_q || s2_load;
        inReady = s1_load;
    end

    // Stage 1 next state: capture the decided beat when the stage advances.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (s1_load) begin
            s1_valid_d = inValid;
            if (inValid) begin
                s1_data_d.sign     = inSign;
                s1_data_d.exp      = inExp;
                s1_data_d.frac     = inFrac;
                s1_data_d.round_up = dec_round_up;
                s1_data_d.inexact  = dec_inexact;
            end
        end
    end

    // Stage 2 next state: apply increment, carry into exponent, saturate to infinity.
    always_comb begin
        frac_sum   = {1'b0, s1_data_q.frac} + {{FRAC{1'b0}}, s1_data_q.round_up};
        exp_inc    = s1_data_q.exp + {{(EXP-1){1'b0}}, 1'b1};
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d.sign     = s1_data_q.sign;
                s2_data_d.exp      = s1_data_q.exp;
                s2_data_d.frac     = frac_sum[FRAC-1:0];
                s2_data_d.inexact  = s1_data_q.inexact;
                s2_data_d.overflow = 1'b0;
                if (frac_sum[FRAC]) begin
                    // exp is never all-ones here (round-up is suppressed), so
                    // exp_inc cannot wrap; reaching all-ones is the overflow case.
                    s2_data_d.frac     = '0;
                    s2_data_d.exp      = exp_inc;
                    s2_data_d.overflow = (exp_inc == EXP_ALL_ONES);
                end
            end
        end
    end

    // Pipeline registers with synchronous clear of valids and data.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_data_q  <= s1_data_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign outValid    = s2_valid_q;
    assign outSign     = s2_data_q.sign;
    assign outExp      = s2_data_q.exp;
    assign outFrac     = s2_data_q.frac;
    assign outInexact  = s2_data_q.inexact;
    assign outOverflow = s2_data_q.overflow;

endmodule

// File: tb/tb_rne_round_pipe.sv
// Self-checking bench for rne_round_pipe against an arithmetic rounding model.
module tb_rne_round_pipe;

    logic       clock = 1'b0;
    logic       reset;
    logic       inValid, inReady, inSign, inSticky;
    logic [7:0] inExp, inFrac;
    logic [1:0] inTrailing;
    logic       outValid, outReady, outSign, outInexact, outOverflow;
    logic [7:0] outExp, outFrac;
    logic [18:0] obs;

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_q[$];

    always #5 clock = ~clock;

    assign obs = {outSign, outExp, outFrac, outInexact, outOverflow};

    rne_round_pipe dut (
        .clock       (clock),
        .reset       (reset),
        .inValid     (inValid),
        .inReady     (inReady),
        .inSign      (inSign),
        .inExp       (inExp),
        .inFrac      (inFrac),
        .inTrailing  (inTrailing),
        .inSticky    (inSticky),
        .outValid    (outValid),
        .outReady    (outReady),
        .outSign     (outSign),
        .outExp      (outExp),
        .outFrac     (outFrac),
        .outInexact  (outInexact),
        .outOverflow (outOverflow)
    );

    // Rounding by value: compare the discarded part with one half ulp.
    function automatic logic [18:0] model(input logic s, input logic [7:0] e, input logic [7:0] f,
                                          input logic [1:0] t, input logic st);
        int mant;
        int ex;
        bit above, tie, up, inexact, ov;
        inexact = (t != 2'd0) || st;
        tie     = (t == 2'd2) && !st;
        above   = (t == 2'd3) || ((t == 2'd2) && st);
        up      = above || (tie && (f % 2 == 1));
        if (e == 8'd255) up = 1'b0;
        mant = int'(f) + (up ? 1 : 0);
        ex   = int'(e);
        ov   = 1'b0;
        if (mant == 256) begin
            mant = 0;
            ex   = ex + 1;
            if (ex == 255) ov = 1'b1;
        end
        return {s, ex[7:0], mant[7:0], inexact, ov};
    endfunction

    function automatic logic [7:0] rand_exp();
        int r = $urandom_range(0, 9);
        if (r == 0) return 8'hFE;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    function automatic logic [7:0] rand_frac();
        if ($urandom_range(0, 3) == 0) return 8'hFF;
        return 8'($urandom);
    endfunction

    // One cycle: drive on the falling edge, let combinational paths settle.
    task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [7:0] f,
                         input logic [1:0] t, input logic st, input logic ordy);
        @(negedge clock);
        inValid    = v;
        inSign     = s;
        inExp      = e;
        inFrac     = f;
        inTrailing = t;
        inSticky   = st;
        outReady   = ordy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) drive(1'b1, 1'b1, 8'hAA, 8'h55, 2'b11, 1'b1, 1'b1);
        @(negedge clock);
        reset   = 1'b0;
        inValid = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b expected 0", outValid); end
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL reset_outdata: got %h expected 0", obs); end
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b expected 1", inReady); end
        outReady = 1'b0;
        #1;
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inready_stalled: got %b expected 1", inReady); end
        outReady = 1'b1;
    endtask

    typedef struct {
        logic s; logic [7:0] e; logic [7:0] f; logic [1:0] t; logic st;
        logic [7:0] xe; logic [7:0] xf; logic xi; logic xo;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        v[0] = '{1'b0, 8'h10, 8'h04, 2'b10, 1'b0, 8'h10, 8'h04, 1'b1, 1'b0};
        v[1] = '{1'b0, 8'h10, 8'h05, 2'b10, 1'b0, 8'h10, 8'h06, 1'b1, 1'b0};
        v[2] = '{1'b0, 8'h10, 8'h04, 2'b01, 1'b1, 8'h10, 8'h04, 1'b1, 1'b0};
        v[3] = '{1'b1, 8'h10, 8'h04, 2'b11, 1'b1, 8'h10, 8'h05, 1'b1, 1'b0};
        v[4] = '{1'b0, 8'h10, 8'hFF, 2'b11, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0};
        v[5] = '{1'b1, 8'hFE, 8'hFF, 2'b11, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1};
        v[6] = '{1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0};
        v[7] = '{1'b1, 8'h80, 8'h33, 2'b00, 1'b0, 8'h80, 8'h33, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, v[i].s, v[i].e, v[i].f, v[i].t, v[i].st, 1'b1);
            drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
            for (int k = 0; k < 6 && !outValid; k++) drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
            checks++;
            if (outValid !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d_timeout: got outValid=%b expected 1", i, outValid);
            end else if (obs !== {v[i].s, v[i].xe, v[i].xf, v[i].xi, v[i].xo}) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h", i, obs, {v[i].s, v[i].xe, v[i].xf, v[i].xi, v[i].xo});
            end
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_exact_latency();
        for (int i = 0; i < 4; i++) begin
            logic s = 1'($urandom);
            logic [7:0] e = rand_exp();
            logic [7:0] f = rand_frac();
            drive(1'b1, s, e, f, 2'b00, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
            checks++;
            if (outValid !== 1'b0) begin errors++; $display("FAIL exact_%0d_early: got outValid=%b expected 0", i, outValid); end
            drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
            checks++;
            if (outValid !== 1'b1 || obs !== {s, e, f, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL exact_%0d: got v=%b %h expected v=1 %h", i, outValid, obs, {s, e, f, 1'b0, 1'b0});
            end
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [18:0] held = '0;
        logic prev_stall = 1'b0;
        int sent = 0;
        int recv = 0;
        logic s; logic [7:0] e, f; logic [1:0] t; logic st;
        exp_q.delete();
        for (int c = 0; c < 80 && recv < 8; c++) begin
            s = 1'($urandom); e = rand_exp(); f = rand_frac(); t = 2'($urandom); st = 1'($urandom);
            drive(sent < 8, s, e, f, t, st, (c % 4 == 0) || (c % 4 == 3));
            if (outValid && prev_stall) begin
                checks++;
                if (obs !== held) begin errors++; $display("FAIL bp_stable: got %h expected %h", obs, held); end
            end
            if (outValid && outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got %h expected none", obs);
                end else begin
                    logic [18:0] x = exp_q.pop_front();
                    if (obs !== x) begin errors++; $display("FAIL bp_data_%0d: got %h expected %h", recv, obs, x); end
                end
                recv++;
            end
            prev_stall = outValid && !outReady;
            held = obs;
            if (inValid && inReady) begin exp_q.push_back(model(s, e, f, t, st)); sent++; end
        end
        checks++;
        if (recv !== 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_count: got recv=%0d pending=%0d expected 8 0", recv, exp_q.size());
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
            checks++;
            if (outValid !== 1'b0) begin errors++; $display("FAIL bp_dup: got outValid=%b expected 0", outValid); end
        end
    endtask

    task automatic test_random();
        logic s; logic [7:0] e, f; logic [1:0] t; logic st;
        int recv = 0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            s = 1'($urandom); e = rand_exp(); f = rand_frac(); t = 2'($urandom); st = 1'($urandom);
            drive($urandom_range(0, 9) < 7, s, e, f, t, st, $urandom_range(0, 9) < 7);
            if (outValid && outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got %h expected none", obs);
                end else begin
                    logic [18:0] x = exp_q.pop_front();
                    if (obs !== x) begin errors++; $display("FAIL rand_data_%0d: got %h expected %h", recv, obs, x); end
                end
                recv++;
            end
            if (inValid && inReady) exp_q.push_back(model(s, e, f, t, st));
        end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
            if (outValid) begin
                logic [18:0] x = exp_q.pop_front();
                checks++;
                if (obs !== x) begin errors++; $display("FAIL rand_drain: got %h expected %h", obs, x); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost: got pending=%0d expected 0", exp_q.size()); end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic s; logic [7:0] e, f; logic [1:0] t; logic st;
        int sent = 0;
        int recv = 0;
        int first_c = -1;
        int last_c = -1;
        exp_q.delete();
        for (int c = 0; c < 40 && recv < 20; c++) begin
            s = 1'($urandom); e = rand_exp(); f = rand_frac(); t = 2'($urandom); st = 1'($urandom);
            drive(sent < 20, s, e, f, t, st, 1'b1);
            if (sent < 20) begin
                checks++;
                if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_inready: got %b expected 1", inReady); end
            end
            if (outValid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got %h expected none", obs);
                end else begin
                    logic [18:0] x = exp_q.pop_front();
                    if (obs !== x) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", recv, obs, x); end
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                recv++;
            end
            if (inValid && inReady) begin exp_q.push_back(model(s, e, f, t, st)); sent++; end
        end
        checks++;
        if (recv !== 20 || first_c !== 2 || last_c - first_c !== 19) begin
            errors++;
            $display("FAIL b2b_throughput: got recv=%0d first=%0d span=%0d expected 20 2 19", recv, first_c, last_c - first_c);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_stream();
        logic [18:0] xa, xc;
        xa = model(1'b0, 8'h20, 8'h11, 2'b11, 1'b0);
        xc = model(1'b1, 8'h44, 8'h7B, 2'b10, 1'b0);
        drive(1'b1, 1'b0, 8'h20, 8'h11, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h30, 8'h22, 2'b01, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        checks++;
        if (outValid !== 1'b1 || obs !== xa) begin
            errors++; $display("FAIL midrst_inflight: got v=%b %h expected v=1 %h", outValid, obs, xa);
        end
        @(negedge clock);
        reset = 1'b1;
        outReady = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++; $display("FAIL midrst_clear: got v=%b rdy=%b expected v=0 rdy=1", outValid, inReady);
        end
        drive(1'b1, 1'b1, 8'h44, 8'h7B, 2'b10, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("FAIL midrst_ghost: got outValid=%b expected 0", outValid); end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
        checks++;
        if (outValid !== 1'b1 || obs !== xc) begin
            errors++; $display("FAIL midrst_after: got v=%b %h expected v=1 %h", outValid, obs, xc);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("FAIL midrst_tail: got outValid=%b expected 0", outValid); end
    endtask

    initial begin
        reset      = 1'b1;
        inValid    = 1'b0;
        inSign     = 1'b0;
        inExp      = '0;
        inFrac     = '0;
        inTrailing = '0;
        inSticky   = 1'b0;
        outReady   = 1'b1;
        test_reset();
        test_directed();
        test_exact_latency();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
